// File: rtl/trigger_framer.sv
// trigger_framer: packs triggered RFDC sample windows into header/data/footer AXI4-Stream frames.
// Define TRIGGER_FRAMER_TIMESTAMP_EN to stamp headers with a free-running 48-bit cycle counter.
module trigger_framer #(
    parameter int DATA_DELAY       = 2,
    parameter int MAX_FRAME_LEN    = 256,
    parameter int FIFO_DEPTH       = 512,
    parameter int RFDC_TDATA_WIDTH = 128
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        TRIGGER,
    input  logic                        SATURATION_FLAG,
    input  logic                        S_AXIS_TVALID,
    input  logic [RFDC_TDATA_WIDTH-1:0] H_S_AXIS_TDATA,
    input  logic [RFDC_TDATA_WIDTH-1:0] L_S_AXIS_TDATA,
    input  logic [7:0]                  CHANNEL_ID,
    output logic [127:0]                M_AXIS_TDATA,
    output logic                        M_AXIS_TVALID,
    input  logic                        M_AXIS_TREADY,
    output logic                        M_AXIS_TLAST,
    output logic [15:0]                 DROP_COUNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DATA, FOOTER, SKIP} state_t;

    state_t state;
    logic trig_d, sat_d, truncated, sat_any;
    logic [15:0] word_cnt;
    logic [DATA_DELAY:0] vld_pipe;
    logic [RFDC_TDATA_WIDTH-1:0] h_pipe [DATA_DELAY+1];
    logic [RFDC_TDATA_WIDTH-1:0] l_pipe [DATA_DELAY+1];
    logic [128:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, free;
    logic [47:0] timestamp;
    logic rise, room, stop, data_wr, wr, rd, drop;
    logic [127:0] wr_data, data_word;

`ifdef TRIGGER_FRAMER_TIMESTAMP_EN
    always_ff @(posedge ACLK) timestamp <= !ARESETN ? '0 : timestamp + 48'd1;
`else
    assign timestamp = '0;
`endif

    always_ff @(posedge ACLK) begin
        h_pipe[0] <= H_S_AXIS_TDATA;
        l_pipe[0] <= L_S_AXIS_TDATA;
        for (int i = 1; i <= DATA_DELAY; i++) begin
            h_pipe[i] <= h_pipe[i-1];
            l_pipe[i] <= l_pipe[i-1];
        end
    end

    always_ff @(posedge ACLK) vld_pipe <= !ARESETN ? '0 : (DATA_DELAY+1)'({vld_pipe, S_AXIS_TVALID});

    // Usable capacity is FIFO_DEPTH-1 words; one slot per open frame stays reserved for its footer.
    always_comb begin
        rise      = TRIGGER && !trig_d;
        free      = CW'(FIFO_DEPTH - 1) - count;
        room      = free >= CW'(3);
        stop      = word_cnt == 16'(MAX_FRAME_LEN) || free == CW'(1);
        data_wr   = state == DATA && !stop && trig_d && vld_pipe[DATA_DELAY];
        drop      = rise && ((state == IDLE && !room) || state == FOOTER);
        wr        = (state == IDLE && rise && room) || data_wr || state == FOOTER;
        data_word = 128'(sat_d ? l_pipe[DATA_DELAY] : h_pipe[DATA_DELAY]);
        wr_data   = state == FOOTER ? {8'h55, word_cnt, sat_any, truncated, 102'd0} :
                    state == DATA   ? data_word : {8'hAA, CHANNEL_ID, timestamp, 64'd0};
        rd        = M_AXIS_TVALID && M_AXIS_TREADY;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state      <= IDLE;
            trig_d     <= 1'b0;
            sat_d      <= 1'b0;
            truncated  <= 1'b0;
            sat_any    <= 1'b0;
            word_cnt   <= '0;
            DROP_COUNT <= '0;
        end else begin
            trig_d <= TRIGGER;
            sat_d  <= SATURATION_FLAG;
            if (drop && DROP_COUNT != 16'hFFFF) DROP_COUNT <= DROP_COUNT + 16'd1;
            if (data_wr) begin
                word_cnt <= word_cnt + 16'd1;
                sat_any  <= sat_any | sat_d;
            end
            case (state)
                IDLE: if (rise) begin
                    state     <= room ? DATA : SKIP;
                    word_cnt  <= '0;
                    sat_any   <= 1'b0;
                    truncated <= 1'b0;
                end
                DATA: if (stop || !TRIGGER) begin
                    state     <= FOOTER;
                    truncated <= stop;
                end
                FOOTER: state <= TRIGGER ? SKIP : IDLE;
                default: if (!TRIGGER) state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(rd);
            count  <= count + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge ACLK) if (ARESETN && wr) mem[wr_ptr] <= {state == FOOTER, wr_data};

    assign M_AXIS_TVALID = count != '0;
    assign {M_AXIS_TLAST, M_AXIS_TDATA} = M_AXIS_TVALID ? mem[rd_ptr] : '0;
endmodule
